// File: rtl/iter_shift_cmp_unit.sv
// ---------------------------------------------------------------------------
// iter_shift_cmp_unit
//
// Multi-cycle shift / set-less-than execution unit for the ALU datapath.
// The 4-bit operation code is decoded internally into compare-signedness,
// shift direction and arithmetic-fill modes.
// Shifts advance by at most P_STEP bits per clock. Compares and illegal
// codes finish in a single pass.
// A valid/ready handshake on both sides lets the unit stall the pipeline
// while a long shift is in progress.
//
// Ports:
//   i_clk     clock, all state changes on the rising edge
//   i_rst_n   synchronous active-low reset
//   i_valid   request valid
//   o_ready   unit can accept a request (state is IDLE)
//   i_oper    operation code
//   i_a       operand A, the value shifted or compared
//   i_b       operand B, compare operand or shift amount in [SHAMT_W-1:0]
//   o_valid   result valid (state is DONE)
//   i_ready   consumer accepts the result
//   o_result  result, held stable while o_valid is high
//   o_err     unsupported operation code, qualified by o_valid
//   o_busy    state is not IDLE
// ---------------------------------------------------------------------------
module iter_shift_cmp_unit #(
  parameter int DATA_W = 32,
  parameter int P_STEP = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_oper,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_err,
  output logic              o_busy
);

  localparam int SHAMT_W = $clog2(DATA_W);
  // One extra bit so that P_STEP == DATA_W is still representable.
  localparam int STEP_W  = SHAMT_W + 1;
  localparam logic [STEP_W-1:0] STEP = STEP_W'(P_STEP);

  localparam logic [3:0] OP_SLT  = 4'b0001;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   work;
  logic [SHAMT_W-1:0]  remaining;
  logic                shift_left;
  logic                shift_arith;

  // Decode of the incoming request; only used on the accept edge.
  logic                dec_cmp;
  logic                dec_shift;
  logic                dec_left;
  logic                dec_arith;
  logic                dec_lt;
  logic [SHAMT_W-1:0]  dec_shamt;

  always_comb begin
    dec_cmp   = 1'b0;
    dec_shift = 1'b0;
    dec_left  = 1'b0;
    dec_arith = 1'b0;
    dec_lt    = 1'b0;
    dec_shamt = i_b[SHAMT_W-1:0];
    case (i_oper)
      OP_SLT: begin
        dec_cmp = 1'b1;
        dec_lt  = ($signed(i_a) < $signed(i_b));
      end
      OP_SLTU: begin
        dec_cmp = 1'b1;
        dec_lt  = (i_a < i_b);
      end
      OP_SLL: begin
        dec_shift = 1'b1;
        dec_left  = 1'b1;
      end
      OP_SRL: begin
        dec_shift = 1'b1;
      end
      OP_SRA: begin
        dec_shift = 1'b1;
        dec_arith = 1'b1;
      end
      default: begin
        dec_cmp   = 1'b0;
        dec_shift = 1'b0;
      end
    endcase
  end

  // One shift chunk: the step is the smaller of P_STEP and what is left, so
  // the final chunk is partial when the amount is not a multiple of P_STEP.
  logic [STEP_W-1:0]   rem_ext;
  logic [STEP_W-1:0]   step_k;
  logic [DATA_W-1:0]   shifted;
  logic [SHAMT_W-1:0]  rem_next;

  always_comb begin
    rem_ext  = {1'b0, remaining};
    step_k   = (rem_ext < STEP) ? rem_ext : STEP;
    if (shift_left) begin
      shifted = work << step_k;
    end else if (shift_arith) begin
      shifted = $unsigned($signed(work) >>> step_k);
    end else begin
      shifted = work >> step_k;
    end
    rem_next = remaining - step_k[SHAMT_W-1:0];
  end

  // Control FSM and datapath registers. The result is loaded exactly when
  // entering DONE and is left untouched until the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      work        <= '0;
      remaining   <= '0;
      shift_left  <= 1'b0;
      shift_arith <= 1'b0;
      o_result    <= '0;
      o_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            shift_left  <= dec_left;
            shift_arith <= dec_arith;
            if (dec_cmp) begin
              o_result <= {{(DATA_W-1){1'b0}}, dec_lt};
              o_err    <= 1'b0;
              state    <= DONE;
            end else if (!dec_shift) begin
              o_result <= '0;
              o_err    <= 1'b1;
              state    <= DONE;
            end else if (dec_shamt == '0) begin
              o_result <= i_a;
              o_err    <= 1'b0;
              state    <= DONE;
            end else begin
              work      <= i_a;
              remaining <= dec_shamt;
              o_err     <= 1'b0;
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work      <= shifted;
          remaining <= rem_next;
          if (rem_next == '0) begin
            o_result <= shifted;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs are pure decodes of the registered state.
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_iter_shift_cmp_unit.sv
// ---------------------------------------------------------------------------
// tb_iter_shift_cmp_unit
//
// Scoreboard bench for iter_shift_cmp_unit (DATA_W=32, P_STEP=4). The
// stimulus task pushes the reference result, error flag and expected
// latency into a queue; an independent monitor pops and compares whenever
// the DUT completes a result handshake.
// ---------------------------------------------------------------------------
module tb_iter_shift_cmp_unit;

  localparam int DW = 32;
  localparam int PS = 4;

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    int            lat;
    int            acc_cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [3:0]    oper;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          out_valid;
  logic          in_ready;
  logic [DW-1:0] result;
  logic          err;
  logic          busy;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   rand_ready = 0;
  bit   ready_force = 1;

  iter_shift_cmp_unit #(.DATA_W(DW), .P_STEP(PS)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (in_valid),
    .o_ready  (out_ready),
    .i_oper   (oper),
    .i_a      (opa),
    .i_b      (opb),
    .o_valid  (out_valid),
    .i_ready  (in_ready),
    .o_result (result),
    .o_err    (err),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Consumer: drives i_ready shortly after each rising edge.
  initial begin
    in_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      in_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the operation rules, with plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, output logic [DW-1:0] res,
                       output logic e, output int lat);
    int sh;
    logic [2*DW-1:0] ext;
    sh  = int'(b % DW);
    e   = 1'b0;
    lat = 1;
    case (op)
      4'b0001: res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0011: res = (a < b) ? 1 : 0;
      4'b0111: res = a << sh;
      4'b0101: res = a >> sh;
      4'b1001: begin
        ext = {{DW{a[DW-1]}}, a};
        ext = ext >> sh;
        res = ext[DW-1:0];
      end
      default: begin
        res = '0;
        e   = 1'b1;
      end
    endcase
    if (!e && (op == 4'b0111 || op == 4'b0101 || op == 4'b1001) && sh > 0)
      lat = 1 + (sh + PS - 1) / PS;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b);
    exp_t ex;
    model(op, a, b, ex.res, ex.err, ex.lat);
    @(negedge clk);
    in_valid = 1'b1;
    oper     = op;
    opa      = a;
    opb      = b;
    for (int n = 0; n < 300 && !out_ready; n++) @(negedge clk);
    if (!out_ready) begin
      checkOutput("accept_timeout", {31'b0, out_ready}, 1);
      in_valid = 1'b0;
    end else begin
      ex.acc_cyc = cyc;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Monitor: latency on first valid cycle, result/err on every valid cycle,
  // pop on handshake. Any valid with nothing expected is a stale result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!out_valid) begin
        seen = 0;
      end else if (sb.size() == 0) begin
        checkOutput("unexpected_valid", {31'b0, out_valid}, 0);
      end else begin
        if (!seen) begin
          checkOutput("latency", DW'(cyc - sb[0].acc_cyc), DW'(sb[0].lat));
          seen = 1;
        end
        checkOutput("result", result, sb[0].res);
        checkOutput("err", {31'b0, err}, {31'b0, sb[0].err});
        if (in_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic waitDrain();
    for (int n = 0; n < 500 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) checkOutput("drain_timeout", DW'(sb.size()), 0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"},  {31'b0, out_valid}, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_err"},    {31'b0, err}, 0);
    checkOutput({tag, "_busy"},   {31'b0, busy}, 0);
    checkOutput({tag, "_ready"},  {31'b0, out_ready}, 1);
  endtask

  initial begin
    logic [3:0] ops [6];
    ops = '{4'b0001, 4'b0011, 4'b0111, 4'b0101, 4'b1001, 4'b1111};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    oper     = '0;
    opa      = '0;
    opb      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkIdleOutputs("por");

    // Reset in the middle of a long shift abandons it.
    in_valid = 1'b1;
    oper     = 4'b0111;
    opa      = 32'h1234_5678;
    opb      = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midshift_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkIdleOutputs("rst");
    repeat (10) @(negedge clk);
    checkOutput("no_stale_valid", {31'b0, out_valid}, 0);

    // Directed boundary cases with i_ready held high.
    applyStimulus(4'b1001, 32'h8000_0000, 32'd31);
    applyStimulus(4'b0101, 32'hF000_000F, 32'hFFFF_FF05);
    applyStimulus(4'b0001, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(4'b0001, 32'h8000_0001, 32'h8000_0001);
    applyStimulus(4'b0011, 32'h0000_0042, 32'h0000_0042);
    applyStimulus(4'b1111, 32'hDEAD_BEEF, 32'h1);
    applyStimulus(4'b0111, 32'h0000_0003, 32'd4);
    applyStimulus(4'b0101, 32'hFFFF_FFFF, 32'd31);
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd31);
    applyStimulus(4'b0111, 32'hCAFE_F00D, 32'hFFFF_FFE0);
    applyStimulus(4'b1001, 32'h7FFF_FFFF, 32'd8);
    waitDrain();

    // Backpressure: result held, new requests ignored while DONE.
    ready_force = 1'b0;
    applyStimulus(4'b0111, 32'h1, 32'd3);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      if (n == 1) begin
        in_valid = 1'b1;
        oper     = 4'b0011;
        opa      = 32'h5;
        opb      = 32'h9;
      end
      if (n == 4) in_valid = 1'b0;
      checkOutput("bp_valid",  {31'b0, out_valid}, 1);
      checkOutput("bp_result", result, 32'd8);
      checkOutput("bp_ready",  {31'b0, out_ready}, 0);
      @(negedge clk);
    end
    ready_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_release_ready", {31'b0, out_ready}, 1);
    checkOutput("bp_release_valid", {31'b0, out_valid}, 0);
    waitDrain();

    // Randomised operations with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = ops[$urandom_range(0, 5)];
      if (op == 4'b1111) op = 4'($urandom);
      applyStimulus(op, $urandom, $urandom);
    end
    waitDrain();
    rand_ready = 1'b0;
    ready_force = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
